// File: rtl/masked_accum_adder.sv
// Pipelined masked lane adder: per-beat masked sums go through a registered
// binary tree and are accumulated across beats until a beat tagged last.
module masked_accum_adder #(
    parameter int NUM      = 4,
    parameter int bitwidth = 16,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter int SAT      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM-1:0]          ctr,
    input  logic [NUM*bitwidth-1:0] data_in,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        sum,
    output logic [CNT_W-1:0]        out_count,
    output logic                    sat_flag
);

    localparam int LG = $clog2(NUM);
    localparam int TW = bitwidth + LG;

    // Heap-ordered tree: node 0 is the root, leaves sit at NUM-1 .. 2*NUM-2.
    // A single width TW is wide enough for the full lane sum at every level.
    logic [TW-1:0]    node [2*NUM-1];
    logic [LG:0]      vld;
    logic [LG:0]      lst;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic             stall;
    logic             accept;
    logic [ACC_W:0]   t;
    logic [ACC_W-1:0] res;
    logic [CNT_W-1:0] cnt_inc;

    // Handshake: a beat transfers on a rising edge with in_valid & in_ready,
    // a result transfers with out_valid & out_ready. The only backpressure is
    // an unaccepted result, which freezes the whole pipeline.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    assign t       = {1'b0, acc} + (ACC_W+1)'(node[0]);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        res = t[ACC_W-1:0];
        if (t[ACC_W] && (SAT != 0)) begin
            res = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            lst       <= '0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            out_count <= '0;
            sat_flag  <= 1'b0;
            for (int n = 0; n < 2*NUM-1; n++) begin
                node[n] <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < NUM; i++) begin
                node[NUM-1+i] <= ctr[i] ? TW'(data_in[i*bitwidth +: bitwidth]) : '0;
            end
            for (int n = 0; n < NUM-1; n++) begin
                node[n] <= node[2*n+1] + node[2*n+2];
            end
            vld <= {vld[LG-1:0], accept};
            lst <= {lst[LG-1:0], in_last};

            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (vld[LG]) begin
                if (lst[LG]) begin
                    sum       <= res;
                    out_count <= cnt_inc;
                    sat_flag  <= sticky | t[ACC_W];
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sticky    <= 1'b0;
                end else begin
                    acc    <= res;
                    cnt    <= cnt_inc;
                    sticky <= sticky | t[ACC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_masked_accum_adder.sv
// Directed bench for masked_accum_adder: packet-level model with expected
// queue, per-cycle output compare, and literal checks of observed results.
module tb_masked_accum_adder;

    localparam int NUM   = 4;
    localparam int BW    = 16;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam int W     = ACC_W + CNT_W + 1;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [NUM-1:0]        ctr = '0;
    logic [NUM*BW-1:0]     data_in = '0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [ACC_W-1:0]      sum;
    logic [CNT_W-1:0]      out_count;
    logic                  sat_flag;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    masked_accum_adder #(
        .NUM(NUM), .bitwidth(BW), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctr(ctr), .data_in(data_in), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .out_count(out_count), .sat_flag(sat_flag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- model + compare process ----------------
    longint m_acc  = 0;
    longint m_cnt  = 0;
    bit     m_flag = 1'b0;
    bit               prev_stall = 1'b0;
    logic [W-1:0]     held = '0;

    always @(negedge clk) begin
        longint s;
        logic [W-1:0] e;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_flag = 1'b0;
            prev_stall = 1'b0;
        end else begin
            // outputs
            if (out_valid && out_ready) begin
                obs_q.push_back({sat_flag, out_count, sum});
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {sat_flag, out_count, sum}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sum",   sum,       e[ACC_W-1:0]);
                    chk("out_count", out_count, e[ACC_W+CNT_W-1:ACC_W]);
                    chk("out_sat",   sat_flag,  e[W-1]);
                end
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (prev_stall) chk("stall_hold", {sat_flag, out_count, sum}, held);
                held = {sat_flag, out_count, sum};
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            // inputs: a beat presented here transfers on the next rising edge
            if (in_valid && in_ready) begin
                s = 0;
                for (int i = 0; i < NUM; i++)
                    if (ctr[i]) s += longint'(data_in[i*BW +: BW]);
                m_acc += s;
                if (m_acc > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_flag = 1'b1;
                end
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
                if (in_last) begin
                    exp_q.push_back({m_flag, CNT_W'(m_cnt), ACC_W'(m_acc)});
                    m_acc = 0; m_cnt = 0; m_flag = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] m, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3, input logic l);
        bit ok;
        int n;
        ctr = m; data_in = {d3, d2, d1, d0}; in_last = l; in_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", n, 0);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) chk("wait_out_timeout", lat, 0);
    endtask

    task automatic expect_obs(input string name, input longint s, input longint c, input longint f);
        logic [W-1:0] o;
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (obs_q.size() == 0) begin
            chk({name, "_missing"}, 0, 1);
        end else begin
            o = obs_q.pop_front();
            chk({name, "_sum"},   o[ACC_W-1:0], s);
            chk({name, "_count"}, o[ACC_W+CNT_W-1:ACC_W], c);
            chk({name, "_sat"},   o[W-1], f);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_count", out_count, 0);
        chk("reset_sat", sat_flag, 0);
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);

        // single masked beat, latency 3
        send(4'b1011, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        wait_out(lat);
        chk("latency", lat, 3);
        expect_obs("single", 7, 1, 0);

        // two single-beat packets back-to-back: second replaces on handshake edge
        send(4'b0001, 16'd11, 16'd0, 16'd0, 16'd0, 1'b1);
        send(4'b0010, 16'd0, 16'd22, 16'd0, 16'd0, 1'b1);
        expect_obs("b2b_a", 11, 1, 0);
        expect_obs("b2b_b", 22, 1, 0);

        // three full beats then an immediately following packet
        repeat (3) send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        send(4'b0110, 16'd9, 16'd3, 16'd4, 16'd9, 1'b0);
        send(4'b1000, 16'd9, 16'd9, 16'd9, 16'h10, 1'b1);
        expect_obs("four_full", 24'h0FFFF0, 4, 0);
        expect_obs("follow", 23, 2, 0);
        idle(4);
        send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        expect_obs("three_full", 24'h0BFFF4, 3, 0);

        // backpressure: result held, further input blocked, nothing lost
        idle(4);
        out_ready = 1'b0;
        send(4'hF, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        send(4'b0011, 16'd10, 16'd20, 16'd0, 16'd0, 1'b0);
        send(4'b0001, 16'd7, 16'd0, 16'd0, 16'd0, 1'b1);
        wait_out(lat);
        ctr = 4'b1000; data_in = {16'd100, 16'd0, 16'd0, 16'd0}; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, 10);
            chk("bp_count", out_count, 1);
        end
        out_ready = 1'b1;
        send(4'b1000, 16'd0, 16'd0, 16'd0, 16'd100, 1'b1);
        expect_obs("bp_a", 10, 1, 0);
        expect_obs("bp_c", 37, 2, 0);
        expect_obs("bp_d", 100, 1, 0);

        // saturation over 65 beats, then fresh packet
        idle(3);
        for (int i = 0; i < 64; i++) send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        send(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        send(4'b0001, 16'd1, 16'd0, 16'd0, 16'd0, 1'b1);
        expect_obs("sat", 24'hFFFFFF, 65, 1);
        expect_obs("after_sat", 1, 1, 0);

        // empty mask plus gaps
        idle(3);
        send(4'b0000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        idle(2);
        send(4'b0100, 16'd5, 16'd5, 16'd9, 16'd5, 1'b1);
        expect_obs("mask_gap", 9, 2, 0);

        // reset mid-packet
        idle(4);
        send(4'b0001, 16'd100, 16'd0, 16'd0, 16'd0, 1'b0);
        send(4'b0001, 16'd100, 16'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b1;
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_sat", sat_flag, 0);
        rst = 1'b0;
        send(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0, 1'b1);
        expect_obs("post_rst", 5, 1, 0);

        idle(8);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("obs_q_drained", obs_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/masked_accum_adder.md
Name: masked_accum_adder

Overview:
- Pipelined, handshaked successor to the combinational masked lane adder.
- Each beat carries NUM lanes of bitwidth-bit unsigned data plus a per-lane enable mask.
- Enabled lanes are reduced through a registered binary adder tree. Successive beats are accumulated until a beat tagged last, then one packet result is emitted.
- Sits between PE output lanes and the aggregation buffer. Used for multi-beat partial-sum reduction.

Parameters:
- NUM, 4, lane count; power of two, >=2.
- bitwidth, 16, lane data width (unsigned).
- ACC_W, 24, accumulator/result width; must be >= bitwidth+log2(NUM).
- CNT_W, 8, beat-count width.
- SAT, 1, 1 = saturate accumulator at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- ctr  in  NUM  lane enable mask; bit i gates lane i.
- data_in  in  NUM*bitwidth  lane i at [i*bitwidth+bitwidth-1 : i*bitwidth].
- in_last  in  1  beat closes the packet.
- out_valid  out  1  packet result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  ACC_W  packet sum.
- out_count  out  CNT_W  beats in packet, saturating at 2^CNT_W-1.
- sat_flag  out  1  packet overflowed (SAT=1) or wrapped (SAT=0).

Behaviour:
- Reset: out_valid=0, sum=0, out_count=0, sat_flag=0, accumulator=0, beat counter=0, all stage valid bits=0. Any partial packet is discarded.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - On stall, every pipeline register, including valid bits, holds.
  - No other backpressure source exists.
- Accept: a beat is accepted on an edge where in_valid & in_ready. Beats are not accepted during rst.
- Stage 0 (mask register): lane i = ctr[i] ? data_i : 0, zero-extended to bitwidth+log2(NUM). in_last is carried along.
- Tree: log2(NUM) registered levels of pairwise adds. Each level is widened so no overflow occurs inside the tree. Valid and last bits travel with the data.
- Accumulation stage, acting when the tree output is valid and not stalled:
  - Compute t = acc + tree_out, evaluated at ACC_W+1 bits.
  - Overflow occurs when t >= 2^ACC_W.
    - SAT=1: the value clamps to 2^ACC_W-1 and stays there for the rest of the packet.
    - SAT=0: the value wraps.
  - Either way, the packet overflow bit is set sticky.
  - Not last: acc <= result; beat counter increments (saturating); out_valid unchanged.
  - Last: sum <= result; out_count <= counter+1 (saturating); sat_flag <= sticky|overflow_now; out_valid <= 1; acc, counter and sticky clear to 0 on the same edge.
- Output handshake:
  - out_valid falls on the edge where out_valid & out_ready, unless a new last beat completes on that same edge. In that case out_valid stays 1 and sum, out_count and sat_flag are replaced.
  - sum, out_count and sat_flag are stable while out_valid & ~out_ready.
- Latency: a last beat accepted at edge E produces out_valid high after edge E+log2(NUM)+1, assuming no stall. For NUM=4 that is 3 edges.
  - Throughput is 1 beat/cycle when unstalled.
  - Empty cycles (in_valid=0) are bubbles and do not affect acc.
- Mask handling:
  - ctr=0 beat: contributes 0 but still counts as a beat.
  - ctr all-ones: equivalent to a plain NUM-lane sum.
- Reset mid-operation: all in-flight beats and the partial accumulation are dropped. The first packet after reset sums only post-reset beats.

Test Plan:
- NUM=4, bitwidth=16, ACC_W=24, CNT_W=8, SAT=1 for all cases.
- Single beat, ctr=4'b1011, lanes0..3 = 1,2,3,4, in_last=1 -> out_valid 3 edges after accept; sum=7, out_count=1, sat_flag=0.
- Three beats, ctr=4'hF, all lanes 16'hFFFF, last on beat 3, back-to-back -> sum=24'h0BFFF4, out_count=3; second packet immediately following is correct.
- Hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, sum/out_count stable, no input beat lost; correct sum after out_ready=1.
- 65 beats of all-ones, last on beat 65 -> sum=24'hFFFFFF, sat_flag=1, out_count=65. Next packet starts from 0 with sat_flag=0.
- Beat with ctr=0 plus beat ctr=4'b0100 lane2=9, in_valid gaps of 2 cycles between beats -> sum=9, out_count=2.
- rst pulse after 2 non-last beats (values 100 each) -> outputs zero. A following single beat of 5 then gives sum=5, out_count=1.
